// File: rtl/pipelined_chunked_add.sv
// Pipelined adder/subtractor that resolves one chunk_width-bit slice per stage.
// Each stage keeps the finished low result bits, the not-yet-summed upper operand
// bits and the ripple carry, so num_chunks operations can be in flight at once.
module pipelined_chunked_add #(
    parameter int unsigned width       = 32,
    parameter int unsigned chunk_width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out,
    output logic             carry_out
);

    localparam int unsigned num_chunks = width / chunk_width;
    localparam int unsigned sum_w      = chunk_width + 1;

    for (genvar s = 0; s < int'(num_chunks); s++) begin : g_stage
        // Operand bits still to be summed when entering this stage, and result bits done after it
        localparam int unsigned in_w  = width - s * chunk_width;
        localparam int unsigned res_w = (s + 1) * chunk_width;

        logic             valid_q;
        logic             carry_q;
        logic [res_w-1:0] res_q;
        logic             load;
        logic             down_ready;
        logic             src_valid;
        logic [in_w-1:0]  a_in;
        logic [in_w-1:0]  b_in;
        logic             cin;
        logic [sum_w-1:0] sum;
        logic [res_w-1:0] res_next;

        // Source of this stage: the block inputs for stage 0, the previous stage otherwise
        if (s == 0) begin : g_src
            assign src_valid = in_valid && in_ready;
            assign a_in      = a;
            assign b_in      = sub ? ~b : b;
            assign cin       = sub;
            assign res_next  = sum[chunk_width-1:0];
        end else begin : g_src
            assign src_valid = g_stage[s-1].valid_q;
            assign a_in      = g_stage[s-1].g_rem.a_q;
            assign b_in      = g_stage[s-1].g_rem.b_q;
            assign cin       = g_stage[s-1].carry_q;
            assign res_next  = {sum[chunk_width-1:0], g_stage[s-1].res_q};
        end

        // Downstream acceptance: the consumer for the last stage, the next stage's load otherwise
        if (s == int'(num_chunks) - 1) begin : g_down
            assign down_ready = out_ready;
        end else begin : g_down
            assign down_ready = g_stage[s+1].load;
        end

        // Stage takes new contents when empty or when its current contents move on
        assign load = !valid_q || down_ready;

        // Chunk sum of the lowest remaining operand slice plus the incoming carry
        assign sum = {1'b0, a_in[chunk_width-1:0]} + {1'b0, b_in[chunk_width-1:0]} + sum_w'(cin);

        // Upper operand slices carried forward for the stages still to come
        if (s < int'(num_chunks) - 1) begin : g_rem
            logic [in_w-chunk_width-1:0] a_q;
            logic [in_w-chunk_width-1:0] b_q;

            // Operand remainder register
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (load && src_valid) begin
                    a_q <= a_in[in_w-1:chunk_width];
                    b_q <= b_in[in_w-1:chunk_width];
                end
            end
        end

        // Stage valid, accumulated result and carry register
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                res_q   <= '0;
            end else if (load) begin
                valid_q <= src_valid;
                if (src_valid) begin
                    res_q   <= res_next;
                    carry_q <= sum[chunk_width];
                end
            end
        end
    end

    // Stage 0 accepts when it can load; nothing is taken while reset is asserted
    assign in_ready  = !rst && g_stage[0].load;

    // Result side comes straight from the last stage's registers
    assign out_valid = g_stage[num_chunks-1].valid_q;
    assign out       = g_stage[num_chunks-1].res_q;
    assign carry_out = g_stage[num_chunks-1].carry_q;

endmodule

// File: tb/tb_pipelined_chunked_add.sv
// Bench for pipelined_chunked_add: three configurations (32/8, 16/16, 64/4) driven
// side by side, each checked against an arithmetic reference with expected queues.
module tb_pipelined_chunked_add;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic        c;
        int          cyc;
    } exp_t;

    int unsigned wid [3] = '{32, 16, 64};
    int unsigned nst [3] = '{4, 1, 16};

    logic [2:0]  iv;
    logic [2:0]  sb;
    logic [2:0]  ordy;
    logic [63:0] a_d [3];
    logic [63:0] b_d [3];
    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [2:0]  co;
    logic [63:0] od [3];
    logic [31:0] out0;
    logic [15:0] out1;
    logic [63:0] out2;

    assign od[0] = 64'(out0);
    assign od[1] = 64'(out1);
    assign od[2] = out2;

    pipelined_chunked_add #(.width(32), .chunk_width(8)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_d[0][31:0]), .b(b_d[0][31:0]), .sub(sb[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out(out0), .carry_out(co[0]));

    pipelined_chunked_add #(.width(16), .chunk_width(16)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_d[1][15:0]), .b(b_d[1][15:0]), .sub(sb[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out(out1), .carry_out(co[1]));

    pipelined_chunked_add #(.width(64), .chunk_width(4)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a_d[2]), .b(b_d[2]), .sub(sb[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out(out2), .carry_out(co[2]));

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    exp_t        q0 [$];
    exp_t        q1 [$];
    exp_t        q2 [$];
    bit          prev_rst = 1'b0;
    bit [2:0]    prev_stall = '0;
    logic [63:0] prev_out [3];
    logic [2:0]  prev_co;
    bit [2:0]    lat_chk = '0;
    bit [2:0]    acc = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] mask_of(input int unsigned w);
        logic [63:0] one = 64'd1;
        return (w >= 64) ? '1 : ((one << w) - 64'd1);
    endfunction

    // Reference: modular sum/difference; carry = unsigned overflow, or no-borrow for sub
    function automatic exp_t ref_op(input int unsigned w, input logic [63:0] x,
                                    input logic [63:0] y, input logic s);
        exp_t        e;
        logic [64:0] full;
        if (!s) begin
            full  = {1'b0, x} + {1'b0, y};
            e.res = full[63:0] & mask_of(w);
            e.c   = ((full >> w) != 65'd0);
        end else begin
            e.res = (x - y) & mask_of(w);
            e.c   = (x >= y);
        end
        e.cyc = 0;
        return e;
    endfunction

    task automatic q_push(input int i, input exp_t e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int q_size(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic q_pop(input int i, output exp_t e, output bit ok);
        ok = (q_size(i) != 0);
        e  = '{res: 64'd0, c: 1'b0, cyc: 0};
        if (ok) begin
            case (i)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
        end
    endtask

    task automatic q_clear(input int i);
        case (i)
            0: q0.delete();
            1: q1.delete();
            default: q2.delete();
        endcase
    endtask

    task automatic set_in(input int i, input bit v, input logic [63:0] x,
                          input logic [63:0] y, input bit s);
        iv[i]  = v;
        a_d[i] = x & mask_of(wid[i]);
        b_d[i] = y & mask_of(wid[i]);
        sb[i]  = s;
    endtask

    // Evaluate one cycle (inputs already set at the falling edge), then move to the next falling edge
    task automatic tick();
        exp_t e;
        bit   ok;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (prev_rst) begin
                check($sformatf("rst_out_valid%0d", i), 64'(ov[i]), 64'd0);
                check($sformatf("rst_out%0d", i), od[i], 64'd0);
                check($sformatf("rst_carry%0d", i), 64'(co[i]), 64'd0);
                if (!rst) check($sformatf("ready_after_rst%0d", i), 64'(ir[i]), 64'd1);
            end
            if (rst) begin
                check($sformatf("rst_in_ready%0d", i), 64'(ir[i]), 64'd0);
                q_clear(i);
                prev_stall[i] = 1'b0;
                acc[i] = 1'b0;
                continue;
            end
            if (prev_stall[i]) begin
                check($sformatf("hold_valid%0d", i), 64'(ov[i]), 64'd1);
                check($sformatf("hold_out%0d", i), od[i], prev_out[i]);
                check($sformatf("hold_carry%0d", i), 64'(co[i]), 64'(prev_co[i]));
            end
            if (ov[i] && ordy[i]) begin
                q_pop(i, e, ok);
                if (!ok) begin
                    check($sformatf("unexpected_out%0d", i), 64'(ov[i]), 64'd0);
                end else begin
                    check($sformatf("out%0d", i), od[i], e.res);
                    check($sformatf("carry%0d", i), 64'(co[i]), 64'(e.c));
                    if (lat_chk[i]) check($sformatf("latency%0d", i), 64'(cyc - e.cyc), 64'(nst[i]));
                end
            end
            prev_stall[i] = ov[i] && !ordy[i];
            prev_out[i]   = od[i];
            prev_co[i]    = co[i];
            acc[i]        = iv[i] && ir[i];
            if (acc[i]) begin
                e     = ref_op(wid[i], a_d[i], b_d[i], sb[i]);
                e.cyc = cyc;
                q_push(i, e);
            end
        end
        prev_rst = rst;
        cyc++;
        @(negedge clk);
    endtask

    // Present one operation on instance i and hold it until accepted (bounded)
    task automatic send(input int i, input logic [63:0] x, input logic [63:0] y, input bit s);
        int waited = 0;
        set_in(i, 1'b1, x, y, s);
        tick();
        while (!acc[i] && waited < 50) begin
            tick();
            waited++;
        end
        if (!acc[i]) check($sformatf("send_timeout%0d", i), 64'(acc[i]), 64'd1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        iv   = '0;
        sb   = '0;
        ordy = '1;
        for (int i = 0; i < 3; i++) begin
            a_d[i]      = '0;
            b_d[i]      = '0;
            prev_out[i] = '0;
        end
        prev_co = '0;
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);

        // Directed cases on the 32/8 instance
        lat_chk = 3'b111;
        send(0, 64'd1, 64'd1, 1'b0);
        iv[0] = 1'b0;
        idle(6);
        send(0, 64'd1234500000, 64'd67890, 1'b0);
        send(0, 64'd4294967290, 64'd5, 1'b0);
        send(0, 64'd4294967290, 64'd4, 1'b0);
        send(0, 64'd4, 64'd4294967290, 1'b0);
        send(0, 64'd4294967295, 64'd1, 1'b0);
        send(0, 64'd5, 64'd7, 1'b1);
        send(0, 64'd7, 64'd5, 1'b1);
        iv[0] = 1'b0;
        idle(6);

        // Backpressure: consumer stalls for 5 cycles while 6 adds are offered
        lat_chk[0] = 1'b0;
        begin
            int sent = 0;
            for (int k = 0; k < 30; k++) begin
                ordy[0] = (k >= 5);
                if (sent < 6) set_in(0, 1'b1, 64'(100 + sent), 64'(sent * 1000), 1'b0);
                else iv[0] = 1'b0;
                if (k == 4) begin
                    #1;
                    check("bp_accepted", 64'(sent), 64'd4);
                    check("bp_in_ready", 64'(ir[0]), 64'd0);
                end
                tick();
                if (acc[0]) sent++;
            end
            check("bp_sent", 64'(sent), 64'd6);
            check("bp_drained", 64'(q_size(0)), 64'd0);
        end
        lat_chk[0] = 1'b1;

        // Reset mid-stream discards in-flight work; inputs during reset are refused
        send(0, 64'd11, 64'd22, 1'b0);
        send(0, 64'd33, 64'd44, 1'b0);
        send(0, 64'd55, 64'd66, 1'b0);
        set_in(0, 1'b1, 64'd9, 64'd9, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send(0, 64'd1, 64'd1, 1'b0);
        iv[0] = 1'b0;
        idle(8);

        // Randomized traffic on all three configurations, consumer always ready
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 3; i++)
                set_in(i, ($urandom_range(0, 3) != 0), {$urandom, $urandom},
                       ($urandom_range(0, 7) == 0) ? a_d[i] : {$urandom, $urandom},
                       1'($urandom_range(0, 1)));
            tick();
        end

        // Randomized traffic with random consumer backpressure
        lat_chk = '0;
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 3; i++) begin
                set_in(i, ($urandom_range(0, 3) != 0), {$urandom, $urandom},
                       {$urandom, $urandom}, 1'($urandom_range(0, 1)));
                ordy[i] = ($urandom_range(0, 2) != 0);
            end
            tick();
        end

        // Drain everything still in flight, bounded
        iv   = '0;
        ordy = '1;
        begin
            int waited = 0;
            while ((q_size(0) + q_size(1) + q_size(2)) != 0 && waited < 200) begin
                tick();
                waited++;
            end
        end
        for (int i = 0; i < 3; i++) check($sformatf("final_pending%0d", i), 64'(q_size(i)), 64'd0);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipelined_chunked_add.md
PIPELINED_CHUNKED_ADD -- requirements
Module: pipelined_chunked_add

Interface
REQ-001 SHALL provide parameter: width, 32, operand and result width in bits.
REQ-002 SHALL provide parameter: chunk_width, 8, bits summed per pipeline stage; width SHALL be an integer multiple of chunk_width.
REQ-003 SHALL derive localparam: num_chunks = width/chunk_width, the pipeline depth and latency.
REQ-004 SHALL have ports (clock and reset first):
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  width  operand A.
- b  input  width  operand B.
- sub  input  1  0 = a+b, 1 = a-b.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out  output  width  result modulo 2^width.
- carry_out  output  1  carry out of MSB chunk.

Function
REQ-005 SHALL transfer input when in_valid && in_ready on a rising clk edge; SHALL transfer output when out_valid && out_ready.
REQ-006 SHALL hold num_chunks stages; stage s (0 = first) SHALL compute result bits [(s+1)*chunk_width-1 : s*chunk_width] plus a carry.
REQ-007 Stage 0 carry-in SHALL equal sub; stage s>0 carry-in SHALL be stage s-1's registered carry.
REQ-008 B operand SHALL be bitwise inverted when sub=1 (two's-complement a + ~b + 1).
REQ-009 Each stage SHALL register: valid bit, completed lower result chunks, remaining upper a/b chunks, sub-adjusted b, carry.
REQ-010 Stage s SHALL load from stage s-1 (stage 0 from inputs) iff its own valid is 0 or it is passing its contents downstream that cycle.
REQ-011 in_ready SHALL equal !stage0_valid || stage0_advancing, combinational, no dependence on in_valid.
REQ-012 out_valid, out, carry_out SHALL be driven directly by the last stage's registers.
REQ-013 Latency SHALL be exactly num_chunks cycles from input transfer to out_valid with out_ready held high.
REQ-014 Throughput SHALL be one transfer per cycle with out_ready held high; no bubbles inserted.
REQ-015 With out_ready low, out, carry_out, out_valid SHALL hold stable; upstream stages SHALL fill, then in_ready SHALL deassert; no data lost or duplicated.
REQ-016 Simultaneous output drain and input accept on a full pipeline SHALL both complete in the same cycle.
REQ-017 Results SHALL wrap modulo 2^width; carry_out SHALL be 1 on unsigned add overflow and, for sub, 1 iff a >= b (no borrow).
REQ-018 num_chunks = 1 SHALL produce a single-stage registered adder with latency 1.
REQ-019 Transactions SHALL exit in acceptance order; sub SHALL be tracked per transaction.

Reset
REQ-020 While rst is high at a clk edge, all stage valid bits, out, carry_out SHALL clear to 0; out_valid SHALL be 0 the following cycle.
REQ-021 in_ready SHALL be 0 while rst is high, and SHALL be 1 in the first cycle after rst falls.
REQ-022 Reset mid-operation SHALL discard every in-flight transaction; none SHALL appear on the output afterward.
REQ-023 Inputs presented in the same cycle as rst high SHALL NOT be accepted.

Verification
REQ-024 width=32, chunk_width=8, out_ready=1: a=1, b=1, sub=0 -> out=2, carry_out=0, out_valid exactly 4 cycles after acceptance.
REQ-025 Back-to-back adds (1234500000+67890, 4294967290+5, 4294967290+4, 4+4294967290) -> out 1234567890, 4294967295, 4294967294, 4294967294 on 4 consecutive cycles, carry_out=0.
REQ-026 Carry across every chunk: 4294967295+1 -> out=0, carry_out=1; sub: 5-7 -> out=4294967294, carry_out=0; 7-5 -> out=2, carry_out=1.
REQ-027 Backpressure: stream 6 adds, out_ready low 5 cycles then high -> in_ready falls once 4 are in flight; all 6 results exit in order, unchanged while stalled.
REQ-028 Reset mid-stream: 3 transactions accepted, rst high for 1 cycle -> out_valid=0 next cycle, no stale results; next accepted 1+1 -> out=2 after 4 cycles.
REQ-029 Parameter sweep width=16, chunk_width=16 and width=64, chunk_width=4: randomized a, b, sub vs reference model -> zero mismatches, latency 1 and 16.
